mem_req_ctrl: RTL and testbench
===============================

# mem_req_ctrl

Request controller and EX/MEM boundary latch between the execute stage and the stalling data-memory stage (`mem_system` behind `memory`). It captures one execute-stage instruction, presents address, write data and a one-cycle `memRead`/`memWrite` pulse to the memory stage, and holds address and data stable until `Done`. It freezes upstream stages while an access is outstanding and hands a completed result (load data or ALU result) to writeback.

## Interface
- `TIMEOUT`, default 63: watchdog limit in cycles; used only when `MEM_REQ_WDOG_EN` is defined.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ex_valid`  in  1  execute stage presents an instruction.
- `ex_aluOut`  in  16  address for a memory op, or result for a non-memory op.
- `ex_wrData`  in  16  store data.
- `ex_memRead`, `ex_memWrite`  in  1 each  op type; never both 1.
- `ex_rd`  in  3  destination register.
- `ex_regWrite`  in  1  writeback enable.
- `ex_halt`  in  1  halt instruction; never carries a memory op.
- `stall_out`  out  1  freeze PC/IF/ID/EX this cycle.
- `aluOut`, `wrData`  out  16 each  to memory stage; held while busy.
- `memRead`, `memWrite`  out  1 each  one-cycle request pulse.
- `memoryOut`  in  16  memory read data; valid when `Done`=1.
- `Done`, `Stall`, `err`  in  1 each  from memory stage.
- `wb_valid`  out  1  result valid for one cycle.
- `wb_data`  out  16  load data for reads, `ex_aluOut` otherwise.
- `wb_rd`  out  3  destination register.
- `wb_regWrite`, `wb_halt`, `wb_err`  out  1 each  writeback enable, halt, and error flag.

## Operation
- States: IDLE, REQ, WAIT. A sticky `halted` flag blocks further accepts.
- Accept condition: `ex_valid & ~halted & (state==IDLE | Done)`.
- Non-memory op on accept: the next cycle drives `wb_valid`=1 with `wb_data`=`ex_aluOut`; the state remains IDLE.
- Memory op on accept: latch `aluOut`, `wrData`, `rd`, `regWrite` and the op type, then go to REQ.
- REQ: `memRead`/`memWrite`=1 for exactly this cycle.
  - `Done`=1 goes to completion.
  - Otherwise go to WAIT.
- WAIT: request outputs are 0. `aluOut`/`wrData` are unchanged. Stay in WAIT until `Done`=1.
- Completion (the `Done` cycle):
  - Capture `memoryOut` for reads, or the latched address for writes, into `wb_data`.
  - The next cycle drives `wb_valid`=1 with `wb_regWrite` = latched value & read.
  - The same cycle may accept a new instruction: memory op goes to REQ, otherwise IDLE.
- `stall_out` = (state==REQ | state==WAIT) & ~`Done`. It is combinational from `Done`.
- `err`=1 in any busy cycle sets a pending error, which is reported as `wb_err` with the completing result and then cleared.
- `ex_halt` accepted: `wb_halt`=1 next cycle and `halted` sets. After that, `stall_out` stays 0 and `ex_valid` is ignored until reset.
- `Stall` is informational only. `Done` alone ends an access.

## Timing
- Reset: state IDLE, `halted`=0, pending error cleared, every output 0.
- Reset mid-access abandons the request. No `wb_valid` is produced.
- Non-memory op latency: accept at T gives `wb_valid` at T+1.
- Memory op latency: accept at T puts the request at T+1. `Done` at T+k (k≥1) gives `wb_valid` at T+k+1.
- Minimum memory latency is 2 cycles, with a hit at T+1.
- `wb_valid` is high for one cycle per accepted instruction. Results stay in order with no loss and no duplication.
- Back-to-back memory ops: the second request pulse occurs in the cycle after the first op's `Done`.

## Configuration
- Macro `MEM_REQ_WDOG_EN`.
- Defined:
  - A 6-bit busy-cycle counter runs in REQ/WAIT and resets on each accept.
  - When it reaches `TIMEOUT` without `Done`, force completion: `wb_data`=0, `wb_err`=1, return to IDLE.
- Undefined: no counter, and WAIT may last forever.

## Test plan
- Reset with `rst_n`=0 mid-WAIT, asynchronously → all outputs 0 immediately; no `wb_valid` after release.
- Non-memory op, `ex_aluOut`=0x1234, `rd`=5 → `wb_valid` next cycle with `wb_data`=0x1234, `wb_rd`=5, `stall_out`=0 throughout.
- Load at addr 0x0040, `Done` in the REQ cycle, `memoryOut`=0xBEEF → `memRead` 1 cycle, `wb_data`=0xBEEF at T+2, `stall_out` never 1.
- Store 0x00AA to 0x0100, `Done` after 4 WAIT cycles → `memWrite` 1 cycle only, addr/data stable, `stall_out`=1 for 4 cycles, `wb_regWrite`=0.
- Load at 0x0002 with `err`=1 in WAIT, then a second load accepted in the `Done` cycle → first result has `wb_err`=1, second has `wb_err`=0, second request pulse one cycle after `Done`.
- Halt followed by `ex_valid` with a load → `wb_halt`=1 once, no further `memRead`.
- With `MEM_REQ_WDOG_EN` and `TIMEOUT`=8, `Done` held 0 → forced completion with `wb_err`=1, `wb_data`=0.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// EX/MEM request controller: one outstanding data-memory access, in-order writeback.
// Optional watchdog forced completion is enabled by defining MEM_REQ_WDOG_EN.
module mem_req_ctrl #(
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [15:0] ex_aluOut,
  input  logic [15:0] ex_wrData,
  input  logic        ex_memRead,
  input  logic        ex_memWrite,
  input  logic [2:0]  ex_rd,
  input  logic        ex_regWrite,
  input  logic        ex_halt,
  output logic        stall_out,
  output logic [15:0] aluOut,
  output logic [15:0] wrData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [15:0] memoryOut,
  input  logic        Done,
  input  logic        Stall,
  input  logic        err,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_rd,
  output logic        wb_regWrite,
  output logic        wb_halt,
  output logic        wb_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } stateT;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        regWrite;
    logic        halt;
    logic        err;
  } wbResT;

  stateT       state;
  logic        halted;
  logic        errPend;
  logic        isRead;
  logic [2:0]  rdLat;
  logic        regWriteLat;
  wbResT       skid;
  logic        skidValid;

  logic        busy;
  logic        accept;
  logic        isMemOp;
  logic        newValid;
  logic        wdFire;
  logic        endAccess;
  wbResT       compRes;
  wbResT       newRes;
  wbResT       outRes;
  wbResT       skidNext;
  logic        outValid;
  logic        skidValidNext;

  assign busy      = (state == REQ) || (state == WAIT);
  assign stall_out = busy & ~Done;
  assign isMemOp   = ex_memRead | ex_memWrite;
  assign accept    = ex_valid & ~halted & ((state == IDLE) | Done);
  assign newValid  = accept & ~isMemOp;
  assign endAccess = busy & (Done | wdFire);

  logic unusedStall;
  assign unusedStall = Stall;

`ifdef MEM_REQ_WDOG_EN
  logic [5:0] wdCnt;

  assign wdFire = busy & ~Done & (wdCnt == 6'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdCnt <= 6'd0;
    end else if (accept) begin
      wdCnt <= 6'd0;
    end else if (busy & ~Done) begin
      wdCnt <= wdCnt + 6'd1;
    end
  end
`else
  logic unusedTimeout;
  assign wdFire        = 1'b0;
  assign unusedTimeout = (TIMEOUT != 0);
`endif

  always_comb begin
    compRes          = '0;
    compRes.data     = Done ? (isRead ? memoryOut : aluOut) : 16'h0000;
    compRes.rd       = rdLat;
    compRes.regWrite = regWriteLat & isRead;
    compRes.err      = errPend | err | wdFire;
    newRes           = '0;
    newRes.data      = ex_aluOut;
    newRes.rd        = ex_rd;
    newRes.regWrite  = ex_regWrite;
    newRes.halt      = ex_halt;
  end

  // A completion and a non-memory accept can land in the same cycle; the
  // younger result parks in the skid slot so writeback stays one-per-cycle.
  always_comb begin
    outValid      = 1'b0;
    outRes        = '0;
    skidValidNext = 1'b0;
    skidNext      = '0;
    if (skidValid) begin
      outValid = 1'b1;
      outRes   = skid;
      if (endAccess) begin
        skidValidNext = 1'b1;
        skidNext      = compRes;
      end else if (newValid) begin
        skidValidNext = 1'b1;
        skidNext      = newRes;
      end
    end else if (endAccess) begin
      outValid = 1'b1;
      outRes   = compRes;
      if (newValid) begin
        skidValidNext = 1'b1;
        skidNext      = newRes;
      end
    end else if (newValid) begin
      outValid = 1'b1;
      outRes   = newRes;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      halted      <= 1'b0;
      errPend     <= 1'b0;
      isRead      <= 1'b0;
      rdLat       <= 3'd0;
      regWriteLat <= 1'b0;
      aluOut      <= 16'h0000;
      wrData      <= 16'h0000;
      memRead     <= 1'b0;
      memWrite    <= 1'b0;
      skid        <= '0;
      skidValid   <= 1'b0;
      wb_valid    <= 1'b0;
      wb_data     <= 16'h0000;
      wb_rd       <= 3'd0;
      wb_regWrite <= 1'b0;
      wb_halt     <= 1'b0;
      wb_err      <= 1'b0;
    end else begin
      memRead   <= accept & ex_memRead;
      memWrite  <= accept & ex_memWrite;
      skid      <= skidNext;
      skidValid <= skidValidNext;
      wb_valid  <= outValid;
      {wb_data, wb_rd, wb_regWrite, wb_halt, wb_err} <= outRes;

      if (accept & ex_halt) begin
        halted <= 1'b1;
      end

      // Error seen in the completing cycle is folded into compRes directly.
      if (endAccess) begin
        errPend <= 1'b0;
      end else if (busy & err) begin
        errPend <= 1'b1;
      end

      if (accept & isMemOp) begin
        aluOut      <= ex_aluOut;
        wrData      <= ex_wrData;
        rdLat       <= ex_rd;
        regWriteLat <= ex_regWrite;
        isRead      <= ex_memRead;
        state       <= REQ;
      end else if (endAccess) begin
        state <= IDLE;
      end else if (state == REQ) begin
        state <= WAIT;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: directed scenarios plus randomized traffic against an
// in-order result queue and a behavioural memory stage; MEM_REQ_WDOG_EN adds a timeout case.
module tb_mem_req_ctrl;

  localparam int TbTimeout = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [15:0] ex_aluOut = '0;
  logic [15:0] ex_wrData = '0;
  logic        ex_memRead = 1'b0;
  logic        ex_memWrite = 1'b0;
  logic [2:0]  ex_rd = '0;
  logic        ex_regWrite = 1'b0;
  logic        ex_halt = 1'b0;
  logic        stall_out;
  logic [15:0] aluOut;
  logic [15:0] wrData;
  logic        memRead;
  logic        memWrite;
  logic [15:0] memoryOut = '0;
  logic        Done = 1'b0;
  logic        Stall = 1'b0;
  logic        err = 1'b0;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_regWrite;
  logic        wb_halt;
  logic        wb_err;

  mem_req_ctrl #(.TIMEOUT(TbTimeout)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_aluOut(ex_aluOut), .ex_wrData(ex_wrData),
    .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_rd(ex_rd),
    .ex_regWrite(ex_regWrite), .ex_halt(ex_halt),
    .stall_out(stall_out), .aluOut(aluOut), .wrData(wrData),
    .memRead(memRead), .memWrite(memWrite),
    .memoryOut(memoryOut), .Done(Done), .Stall(Stall), .err(err),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_regWrite(wb_regWrite), .wb_halt(wb_halt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  logic [57:0] allOuts;
  assign allOuts = {stall_out, aluOut, wrData, memRead, memWrite, wb_valid,
                    wb_data, wb_rd, wb_regWrite, wb_halt, wb_err};

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        regWrite;
    logic        halt;
    logic        err;
  } resT;

  typedef struct {
    bit          isRd;
    bit          isWr;
    bit          halt;
    logic [15:0] addr;
    logic [15:0] data;
    logic [2:0]  rd;
    bit          regWrite;
  } instT;

  int   tests = 0;
  int   fails = 0;
  resT  expQ[$];
  instT instQ[$];
  int   latQ[$];
  bit   errQ[$];
  int   reqLog[$];
  int   doneLog[$];
  logic [15:0] tbMem [16];

  instT cur, infl;
  bit   curValid, outstanding, reqPending, expectPulse, errAcc, tbHalted, errPlan, randomMode;
  int   delayLeft, busyN, cyc, acceptCyc, wbCyc, pulseCount, stallCount, wbCount;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic resT mkRes(logic [15:0] d, logic [2:0] r, logic rw, logic h, logic e);
    resT x;
    x.data = d; x.rd = r; x.regWrite = rw; x.halt = h; x.err = e;
    return x;
  endfunction

  function automatic instT mkInst(bit rdOp, bit wrOp, bit h, logic [15:0] a,
                                  logic [15:0] d, logic [2:0] r, bit rw);
    instT x;
    x.isRd = rdOp; x.isWr = wrOp; x.halt = h; x.addr = a; x.data = d; x.rd = r; x.regWrite = rw;
    return x;
  endfunction

  task automatic clearStamps();
    pulseCount = 0; stallCount = 0;
    reqLog.delete(); doneLog.delete();
  endtask

  // One clock of the execute stage, memory stage and result scoreboard.
  task automatic clockCycle();
    bit done, errIn, consumed, expStall, fire;
    resT e;
    fire = 1'b0;
    if (!curValid && instQ.size() > 0 && (!randomMode || $urandom_range(0, 2) != 0)) begin
      cur = instQ.pop_front();
      curValid = 1'b1;
    end
    if (curValid) begin
      ex_valid = 1'b1; ex_aluOut = cur.addr; ex_wrData = cur.data;
      ex_memRead = cur.isRd; ex_memWrite = cur.isWr; ex_rd = cur.rd;
      ex_regWrite = cur.regWrite; ex_halt = cur.halt;
    end else begin
      ex_valid = 1'b0; ex_aluOut = 16'($urandom); ex_wrData = 16'($urandom);
      ex_memRead = 1'($urandom); ex_memWrite = 1'b0; ex_rd = 3'($urandom);
      ex_regWrite = 1'($urandom); ex_halt = 1'b0;
    end

    check("memRead_pulse", 64'(memRead), 64'(expectPulse & infl.isRd));
    check("memWrite_pulse", 64'(memWrite), 64'(expectPulse & infl.isWr));
    if (expectPulse) begin
      reqPending = 1'b1; pulseCount++; reqLog.push_back(cyc); busyN = 0;
      delayLeft = (latQ.size() > 0) ? latQ.pop_front() : $urandom_range(0, 4);
      errPlan = (errQ.size() > 0) ? errQ.pop_front() : 1'b0;
      check("req_addr", 64'(aluOut), 64'(infl.addr));
      check("req_data", 64'(wrData), 64'(infl.data));
    end else if (reqPending) begin
      check("hold_addr", 64'(aluOut), 64'(infl.addr));
      check("hold_data", 64'(wrData), 64'(infl.data));
    end
    expectPulse = 1'b0;

    done = reqPending && (delayLeft == 0);
    if (reqPending) errIn = errPlan ? (delayLeft == 1) : (randomMode && $urandom_range(0, 5) == 0);
    else errIn = randomMode && ($urandom_range(0, 5) == 0);
    Done = done; err = errIn; Stall = reqPending && !done;
    memoryOut = (done && infl.isRd) ? tbMem[infl.addr[3:0]] : 16'($urandom);
    #1;

`ifdef MEM_REQ_WDOG_EN
    fire = reqPending && !done && (busyN == TbTimeout - 1);
`endif
    expStall = outstanding && !done;
    check("stall_out", 64'(stall_out), 64'(expStall));
    if (expStall) stallCount++;
    consumed = curValid && !tbHalted && !expStall;

    if (done || fire) begin
      if (done) expQ.push_back(mkRes(infl.isRd ? tbMem[infl.addr[3:0]] : infl.addr, infl.rd,
                                     infl.regWrite & infl.isRd, 1'b0, errAcc | errIn));
      else expQ.push_back(mkRes(16'h0000, infl.rd, infl.regWrite & infl.isRd, 1'b0, 1'b1));
      if (done && infl.isWr) tbMem[infl.addr[3:0]] = infl.data;
      outstanding = 1'b0; reqPending = 1'b0; errAcc = 1'b0; doneLog.push_back(cyc);
    end else if (reqPending) begin
      delayLeft--; busyN++; errAcc |= errIn;
    end

    if (consumed) begin
      acceptCyc = cyc; curValid = 1'b0;
      if (cur.isRd || cur.isWr) begin
        infl = cur; outstanding = 1'b1; expectPulse = 1'b1;
      end else begin
        expQ.push_back(mkRes(cur.addr, cur.rd, cur.regWrite, cur.halt, 1'b0));
        if (cur.halt) tbHalted = 1'b1;
      end
    end

    @(posedge clk); #1;
    cyc++;
    if (wb_valid) begin
      wbCount++; wbCyc = cyc;
      if (expQ.size() == 0) begin
        check("wb_unexpected", 64'(wb_valid), 64'(0));
      end else begin
        e = expQ.pop_front();
        check("wb_result", 64'({wb_data, wb_rd, wb_regWrite, wb_halt, wb_err}), 64'(e));
      end
    end
  endtask

  task automatic runUntilDone(input int budget);
    int n;
    n = 0;
    while ((instQ.size() > 0 || curValid || reqPending || outstanding || expQ.size() > 0) && n < budget) begin
      clockCycle();
      n++;
    end
    check("drain_in_budget", 64'(n < budget), 64'(1));
  endtask

  task automatic resetModel();
    expQ.delete(); instQ.delete(); latQ.delete(); errQ.delete();
    curValid = 0; outstanding = 0; reqPending = 0; expectPulse = 0;
    errAcc = 0; tbHalted = 0; errPlan = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int wbBefore;
    resetModel();
    randomMode = 0; cyc = 0; wbCount = 0; delayLeft = 0; busyN = 0;
    for (int i = 0; i < 16; i++) tbMem[i] = 16'($urandom);
    clearStamps();

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'(allOuts), 64'(0));
    rst_n = 1'b1;

    // Non-memory op
    clearStamps();
    instQ.push_back(mkInst(0, 0, 0, 16'h1234, 16'h0, 3'd5, 1));
    runUntilDone(20);
    check("nonmem_latency", 64'(wbCyc - acceptCyc), 64'(1));
    check("nonmem_stall", 64'(stallCount), 64'(0));

    // Load hit in the request cycle
    clearStamps();
    tbMem[0] = 16'hBEEF;
    instQ.push_back(mkInst(1, 0, 0, 16'h0040, 16'h5555, 3'd2, 1));
    latQ.push_back(0); errQ.push_back(0);
    runUntilDone(20);
    check("load_req_cycle", 64'(reqLog[0] - acceptCyc), 64'(1));
    check("load_wb_latency", 64'(wbCyc - acceptCyc), 64'(2));
    check("load_pulses", 64'(pulseCount), 64'(1));
    check("load_stall", 64'(stallCount), 64'(0));

    // Store with four stalled cycles
    clearStamps();
    instQ.push_back(mkInst(0, 1, 0, 16'h0100, 16'h00AA, 3'd3, 1));
    latQ.push_back(4); errQ.push_back(0);
    runUntilDone(20);
    check("store_stall", 64'(stallCount), 64'(4));
    check("store_wb", 64'(wbCyc - reqLog[0]), 64'(5));
    check("store_pulses", 64'(pulseCount), 64'(1));

    // Load with error in WAIT, second load accepted in its Done cycle
    clearStamps();
    tbMem[2] = 16'hC0DE;
    instQ.push_back(mkInst(1, 0, 0, 16'h0002, 16'h0, 3'd4, 1));
    instQ.push_back(mkInst(1, 0, 0, 16'h0100, 16'h0, 3'd6, 1));
    latQ.push_back(2); latQ.push_back(1);
    errQ.push_back(1); errQ.push_back(0);
    runUntilDone(30);
    check("b2b_pulses", 64'(pulseCount), 64'(2));
    if (reqLog.size() == 2 && doneLog.size() == 2)
      check("b2b_req_after_done", 64'(reqLog[1] - doneLog[0]), 64'(1));
    else
      check("b2b_log_size", 64'(reqLog.size()), 64'(2));

    // Asynchronous reset while waiting on memory
    clearStamps();
    instQ.push_back(mkInst(1, 0, 0, 16'h0007, 16'h0, 3'd1, 1));
    latQ.push_back(10); errQ.push_back(0);
    repeat (3) clockCycle();
    Done = 1'b0; err = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'(allOuts), 64'(0));
    resetModel();
    ex_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    wbBefore = wbCount;
    repeat (5) clockCycle();
    check("no_wb_after_reset", 64'(wbCount - wbBefore), 64'(0));

    // Randomized traffic
    randomMode = 1;
    clearStamps();
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      instQ.push_back(mkInst(kind == 1, kind == 2, 0,
                             (kind == 0) ? 16'($urandom) : 16'($urandom_range(0, 15)),
                             16'($urandom), 3'($urandom), 1'($urandom)));
    end
    runUntilDone(6000);
    randomMode = 0;

`ifdef MEM_REQ_WDOG_EN
    // Memory never answers; watchdog forces an erroring completion
    clearStamps();
    instQ.push_back(mkInst(1, 0, 0, 16'h0005, 16'h0, 3'd7, 1));
    latQ.push_back(1000); errQ.push_back(0);
    runUntilDone(40);
    check("wdog_latency", 64'(wbCyc - acceptCyc), 64'(TbTimeout + 1));
`endif

    // Halt, then a load that must never be issued
    clearStamps();
    wbBefore = wbCount;
    instQ.push_back(mkInst(0, 0, 1, 16'h7777, 16'h0, 3'd1, 0));
    instQ.push_back(mkInst(1, 0, 0, 16'h0003, 16'h0, 3'd2, 1));
    repeat (10) clockCycle();
    check("halt_wb_count", 64'(wbCount - wbBefore), 64'(1));
    check("halt_no_req", 64'(pulseCount), 64'(0));
    check("halt_no_stall", 64'(stallCount), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
